// File: rtl/overlap_add_buffer.sv
// Overlap-add synthesis buffer: hop N/2 frames in, continuous overlap-added samples out.
// Optional macro OLA_SATURATE_EN: clamp sums instead of two's-complement wrap.
module overlap_add_buffer #(
    parameter int ADDRWIDTH = 12,
    parameter int DATAWIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    output logic [ADDRWIDTH-1:0] window_addr,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sync_error
);
    localparam int HALF = 1 << (ADDRWIDTH - 1);

    logic                 stall;
    logic                 accept;
    logic                 first_half;
    logic                 take_first;
    logic                 at_end;
    logic                 primed;
    logic [ADDRWIDTH-2:0] ram_addr;

    logic [DATAWIDTH-1:0] mem [HALF];
    logic [DATAWIDTH-1:0] rd_data;

    logic [2:1]           vld_pipe;
    logic [DATAWIDTH-1:0] s1_data;
    logic                 s1_primed;
    logic [DATAWIDTH-1:0] partial;
    logic signed [DATAWIDTH:0] sum;
    logic [DATAWIDTH-1:0] sum_red;

    assign stall      = out_valid && !out_ready;
    assign in_ready   = !stall;
    assign accept     = in_valid && in_ready;
    assign first_half = !window_addr[ADDRWIDTH-1];
    assign take_first = accept && first_half;
    assign at_end     = &window_addr;
    assign ram_addr   = window_addr[ADDRWIDTH-2:0];
    assign out_valid  = vld_pipe[2];

    // Frame counter, priming and alignment check
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            window_addr <= '0;
            primed      <= 1'b0;
            sync_error  <= 1'b0;
        end else if (accept) begin
            if (in_last && !at_end) begin
                sync_error  <= 1'b1;
                window_addr <= '0;
                primed      <= 1'b0;
            end else begin
                window_addr <= window_addr + 1'b1;
                if (at_end && !in_last) sync_error <= 1'b1;
                if (at_end && in_last)  primed     <= 1'b1;
            end
        end
    end

    // Second-half samples park in RAM; first-half accepts fetch last frame's tail.
    // rd_data only moves on an accept, so it holds across stalls.
    always_ff @(posedge clock) begin
        if (accept && !first_half) mem[ram_addr] <= in_data;
        if (take_first)            rd_data       <= mem[ram_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            s1_data   <= '0;
            s1_primed <= 1'b0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[1], take_first};
            if (take_first) begin
                s1_data   <= in_data;
                s1_primed <= primed;
            end
        end
    end

    always_comb begin
        partial = s1_primed ? rd_data : '0;
        sum     = $signed({s1_data[DATAWIDTH-1], s1_data}) + $signed({partial[DATAWIDTH-1], partial});
`ifdef OLA_SATURATE_EN
        // Top two bits disagree only on overflow; sign bit picks the rail.
        if (sum[DATAWIDTH] != sum[DATAWIDTH-1])
            sum_red = sum[DATAWIDTH] ? {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
        else
            sum_red = sum[DATAWIDTH-1:0];
`else
        sum_red = sum[DATAWIDTH-1:0];
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) out_data <= '0;
        else if (!stall && vld_pipe[1]) out_data <= sum_red;
    end
endmodule

// File: tb/tb_overlap_add_buffer.sv
// Directed + randomized bench for overlap_add_buffer (N=8, 8-bit) against a frame-level model.
module tb_overlap_add_buffer;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
    localparam int H  = N / 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [AW-1:0] window_addr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          sync_error;

    overlap_add_buffer #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .window_addr(window_addr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sync_error(sync_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: index in frame, primed flag, previous frame's tail, expected output queue
    int m_idx, m_err;
    bit m_primed;
    int m_tail [H];
    int exp_q [$];
    int obs_q [$];
    int cyc = 0, acc_cyc0 = -1, ov_cyc0 = -1;
    bit acc, rnd_rdy = 0;
    int held;
    int d [N];

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int reduce(input int s);
        logic signed [DW-1:0] t;
`ifdef OLA_SATURATE_EN
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
`else
        t = s[DW-1:0];
        return int'(t);
`endif
    endfunction

    task automatic model_reset();
        m_idx = 0; m_err = 0; m_primed = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input int v, input bit last);
        if (m_idx >= H) m_tail[m_idx-H] = v;
        else exp_q.push_back(reduce(v + (m_primed ? m_tail[m_idx] : 0)));
        if (last && m_idx != N-1) begin
            m_err = 1; m_idx = 0; m_primed = 0;
        end else if (m_idx == N-1) begin
            if (!last) m_err = 1;
            else m_primed = 1;
            m_idx = 0;
        end else m_idx++;
    endtask

    // One clock: check state at negedge, update model on handshakes
    task automatic tick();
        @(negedge clock);
        chk("window_addr", int'(window_addr), m_idx);
        chk("sync_error", int'(sync_error), m_err);
        if (ov_cyc0 < 0 && out_valid) ov_cyc0 = cyc;
        if (out_valid && out_ready) begin
            obs_q.push_back(int'($signed(out_data)));
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else chk("out_data", int'($signed(out_data)), exp_q.pop_front());
        end
        acc = in_valid && in_ready;
        if (acc) begin
            if (acc_cyc0 < 0) acc_cyc0 = cyc;
            model_accept(int'($signed(in_data)), in_last);
        end
        cyc++;
        @(posedge clock); #1;
    endtask

    task automatic send(input int v, input bit last);
        int n = 0;
        in_data = v[DW-1:0]; in_last = last; in_valid = 1'b1;
        do begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0; in_last = 1'b0;
        if (rnd_rdy && $urandom_range(0, 4) == 0) tick();
    endtask

    task automatic send_const(input int v);
        for (int i = 0; i < N; i++) send(v, i == N-1);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; rnd_rdy = 0;
        repeat (6) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_window_addr", int'(window_addr), 0);
        chk("rst_sync_error", int'(sync_error), 0);
        chk("rst_out_data", int'(out_data), 0);

        // Three constant frames, first output two cycles after first accept
        obs_q.delete(); acc_cyc0 = -1; ov_cyc0 = -1;
        send_const(1); send_const(2); send_const(3);
        drain();
        chk("latency", ov_cyc0 - acc_cyc0, 2);
        chk("basic_count", obs_q.size(), 12);
        if (obs_q.size() == 12)
            for (int i = 0; i < 12; i++) chk("basic_seq", obs_q[i], (i < 4) ? 1 : (i < 8) ? 3 : 5);

        // Overflow of 100 + 100
        do_reset(); obs_q.delete();
        send_const(100); send_const(100);
        drain();
        if (obs_q.size() == 8)
`ifdef OLA_SATURATE_EN
            for (int i = 4; i < 8; i++) chk("sat_out", obs_q[i], 127);
`else
            for (int i = 4; i < 8; i++) chk("wrap_out", obs_q[i], -56);
`endif
        else chk("sat_count", obs_q.size(), 8);

        // Output backpressure held five cycles mid-frame
        do_reset();
        send_const(10);
        for (int i = 0; i < N; i++) d[i] = int'($urandom_range(0, 255)) - 128;
        send(d[0], 0); send(d[1], 0);
        out_ready = 1'b0; in_data = d[2][DW-1:0]; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) held = int'(out_data);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_hold", int'(out_data), held);
        end
        out_ready = 1'b1;
        for (int i = 2; i < N; i++) send(d[i], i == N-1);
        send_const(20);
        drain();

        // Random data with random backpressure and input gaps
        rnd_rdy = 1;
        for (int f = 0; f < 8; f++)
            for (int i = 0; i < N; i++) send(int'($urandom_range(0, 255)) - 128, i == N-1);
        drain();

        // Early in_last at index 5: next frame passes through unaccumulated
        obs_q.delete();
        for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 255)) - 128, i == 5);
        chk("early_last_err", int'(sync_error), 1);
        chk("early_last_addr", int'(window_addr), 0);
        for (int i = 0; i < N; i++) d[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < N; i++) send(d[i], i == N-1);
        send_const(5);
        drain();
        if (obs_q.size() == 12)
            for (int i = 0; i < H; i++) chk("unprimed_pass", obs_q[4+i], d[i]);
        else chk("early_last_count", obs_q.size(), 12);
        chk("err_sticky", int'(sync_error), 1);

        // Missing in_last at index 7: wrap and keep accumulating
        do_reset(); obs_q.delete();
        send_const(7);
        for (int i = 0; i < N; i++) send(9, 0);
        chk("miss_last_err", int'(sync_error), 1);
        chk("miss_last_addr", int'(window_addr), 0);
        send_const(11);
        drain();
        if (obs_q.size() == 12) begin
            chk("miss_last_acc1", obs_q[4], 16);
            chk("miss_last_acc2", obs_q[8], 20);
        end else chk("miss_last_count", obs_q.size(), 12);

        // Asynchronous reset mid-frame
        send(3, 0); send(3, 0); send(3, 0);
        in_valid = 1'b1; in_data = 8'd3;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_window_addr", int'(window_addr), 0);
        chk("arst_sync_error", int'(sync_error), 0);
        in_valid = 1'b0;
        model_reset();
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        obs_q.delete();
        send_const(4); send_const(6);
        drain();
        if (obs_q.size() == 8) begin
            chk("post_rst_unprimed", obs_q[0], 4);
            chk("post_rst_acc", obs_q[4], 10);
        end else chk("post_rst_count", obs_q.size(), 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/overlap_add_buffer.md
# overlap_add_buffer

Overlap-add synthesis buffer for the pitch-shifter resynthesis path. Accepts a stream of windowed frames of length N = 2^ADDRWIDTH with hop N/2 (oversampling factor 2) and emits a continuous sample stream. Each output sample is the sum of the second half of frame f and the first half of frame f+1. Sits downstream of the inverse-transform/synthesis-window stage, mirroring the overlapped-window FIFO on the analysis side.

## Interface
- ADDRWIDTH, 12, log2 of window length N; N/2-entry internal RAM; minimum 2
- DATAWIDTH, 16, signed two's-complement sample width for in_data/out_data
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  DATAWIDTH  windowed frame sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_last  in  1  marks final sample (index N-1) of a frame
- window_addr  out  ADDRWIDTH  index within the current frame of the next sample to be accepted (for synthesis-window LUT)
- out_data  out  DATAWIDTH  overlap-added output sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- sync_error  out  1  sticky: in_last misaligned with frame counter

## Operation
- Accept = in_valid && in_ready. in_ready = !(out_valid && !out_ready); entire block stalls while output is blocked.
- Frame counter window_addr increments on each accept; wraps N-1 -> 0.
- RAM: N/2 x DATAWIDTH, synchronous read, address = window_addr[ADDRWIDTH-2:0]. Read enable = accept of first-half sample only; RAM read data holds while stalled.
- Second-half sample (window_addr[ADDRWIDTH-1]=1): written to RAM at the offset address; nothing emitted.
- First-half sample (window_addr[ADDRWIDTH-1]=0): stored partial read, summed with in_data, result loaded into output register; one output per first-half sample, N/2 outputs per frame.
- primed flag: cleared on reset or sync error; set on accept at window_addr = N-1 with in_last=1. While primed=0, stored partial is treated as 0 (RAM contents never cleared).
- Sum width DATAWIDTH+1 internally; reduction per Configuration.
- Sync check on accept: in_last=1 at window_addr != N-1 -> sync_error set, window_addr -> 0, primed -> 0. in_last=0 at window_addr = N-1 -> sync_error set, normal wrap, primed unchanged. sync_error cleared only by reset.
- Read-after-write: second-half write to address a (frame f) always precedes first-half read of a (frame f+1) by >= 1 cycle; no bypass needed.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, window_addr=0, sync_error=0, primed=0, pipeline valid bits 0. Reset mid-frame aborts the frame immediately; the next accepted sample is index 0 of an unprimed frame.
- Latency: first-half sample accepted in cycle t -> out_valid=1 with its sum in cycle t+2 (stage 1: RAM read; stage 2: add/reduce into output register).
- out_data/out_valid hold stable while out_valid && !out_ready.
- Throughput: one accept per cycle when out_ready=1.
- window_addr updates on the edge following an accept.

## Configuration
- OLA_SATURATE_EN defined: sum clamps to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
- Not defined: sum truncated to DATAWIDTH LSBs (two's-complement wrap).

## Test plan
- Reset: assert reset_n=0 mid-run -> out_valid=0, in_ready=1, window_addr=0, sync_error=0 asynchronously.
- ADDRWIDTH=3, DATAWIDTH=8, out_ready=1: frame0 all 1, frame1 all 2, frame2 all 3 (in_last on index 7) -> outputs 1,1,1,1,3,3,3,3,5,5,5,5; first out_valid 2 cycles after first accept.
- Saturation: frame0 second half 100, frame1 first half 100 -> outputs 127 with OLA_SATURATE_EN, -56 without.
- Backpressure: drop out_ready for 5 cycles mid-frame -> in_ready=0 while out_valid, out_data constant, no sample lost/duplicated, output sequence identical to unstalled run.
- Sync error: in_last=1 at index 5 -> sync_error=1 (sticky), window_addr=0 next cycle, following frame's first half emitted unaccumulated (equal to in_data).
- Missing in_last at index 7 -> sync_error=1, window_addr wraps to 0, next frame's outputs still accumulated.
